// File: rtl/xbar_banks_pea_sel_sched_pkg.sv
// Shared crossbar sizes and types for the bank/PE selector scheduler.
// DRAIN_CYCLES is only used when the scheduler is built with XBAR_SEL_SCHED_DRAIN_EN.
package xbar_pkg;
    localparam int N_PE_PER_GROUP         = 4;
    localparam int N_BANKS_PER_STREAM     = N_PE_PER_GROUP;
    localparam int LOG_N_PE_PER_GROUP     = $clog2(N_PE_PER_GROUP);
    localparam int LOG_N_BANKS_PER_STREAM = $clog2(N_BANKS_PER_STREAM);
    localparam int N_CFG_ENTRIES          = 8;
    localparam int LOG_N_CFG_ENTRIES      = $clog2(N_CFG_ENTRIES);
    localparam int N_ITER_W               = 16;
    localparam int N_PIPE_STAGE_BANKS_PEA = 3;
    localparam int DRAIN_CYCLES           = N_PIPE_STAGE_BANKS_PEA;

    typedef logic [N_PE_PER_GROUP-1:0][LOG_N_BANKS_PER_STREAM-1:0] sel_dmem_pea_t;
    typedef logic [N_BANKS_PER_STREAM-1:0][LOG_N_PE_PER_GROUP-1:0] sel_pea_dmem_t;

    typedef struct packed {
        sel_dmem_pea_t sel_dmem_pea;
        sel_pea_dmem_t sel_pea_dmem;
    } xbar_sel_cfg_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } xbar_sched_state_e;
endpackage

// File: rtl/xbar_banks_pea_sel_sched_if.sv
// Control/config/selector bundle between the Mage control side (master) and the scheduler (slave).
interface xbar_banks_pea_sel_sched_if;
    import xbar_pkg::*;

    logic                         cfg_we_i;
    logic [LOG_N_CFG_ENTRIES-1:0] cfg_addr_i;
    sel_dmem_pea_t                cfg_sel_dmem_pea_i;
    sel_pea_dmem_t                cfg_sel_pea_dmem_i;
    logic                         start_i;
    logic [LOG_N_CFG_ENTRIES-1:0] last_entry_i;
    logic [N_ITER_W-1:0]          n_iter_i;
    logic                         stall_i;
    logic                         abort_i;
    sel_dmem_pea_t                sel_dmem_pea_o;
    sel_pea_dmem_t                sel_pea_dmem_o;
    logic                         sel_valid_o;
    logic                         cfg_ready_o;
    logic                         busy_o;
    logic                         done_o;

    modport master (
        output cfg_we_i, cfg_addr_i, cfg_sel_dmem_pea_i, cfg_sel_pea_dmem_i,
        output start_i, last_entry_i, n_iter_i, stall_i, abort_i,
        input  sel_dmem_pea_o, sel_pea_dmem_o, sel_valid_o, cfg_ready_o, busy_o, done_o
    );

    modport slave (
        input  cfg_we_i, cfg_addr_i, cfg_sel_dmem_pea_i, cfg_sel_pea_dmem_i,
        input  start_i, last_entry_i, n_iter_i, stall_i, abort_i,
        output sel_dmem_pea_o, sel_pea_dmem_o, sel_valid_o, cfg_ready_o, busy_o, done_o
    );
endinterface

// File: rtl/xbar_banks_pea_sel_sched_cfg_table.sv
// Crossbar configuration register file: one synchronous write port, one combinational read port.
module xbar_sel_cfg_table
    import xbar_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         we_i,
    input  logic [LOG_N_CFG_ENTRIES-1:0] waddr_i,
    input  xbar_sel_cfg_t                wdata_i,
    input  logic [LOG_N_CFG_ENTRIES-1:0] raddr_i,
    output xbar_sel_cfg_t                rdata_o
);
    xbar_sel_cfg_t mem_q [N_CFG_ENTRIES];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_CFG_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/xbar_banks_pea_sel_sched.sv
// Replays crossbar selector entries 0..last for n_iter iterations after a start pulse.
// XBAR_SEL_SCHED_DRAIN_EN adds a DRAIN phase of DRAIN_CYCLES before done is reported.
module xbar_banks_pea_sel_sched
    import xbar_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    xbar_banks_pea_sel_sched_if.slave   bus
);
    localparam logic [N_ITER_W-1:0]          ITER_ONE = N_ITER_W'(1);
    localparam logic [LOG_N_CFG_ENTRIES-1:0] PTR_ONE  = LOG_N_CFG_ENTRIES'(1);

`ifdef XBAR_SEL_SCHED_DRAIN_EN
    localparam int DRAIN_CNT_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);
    logic [DRAIN_CNT_W-1:0] drain_cnt_q;
`endif

    xbar_sched_state_e            state_q;
    logic [LOG_N_CFG_ENTRIES-1:0] ptr_q;
    logic [LOG_N_CFG_ENTRIES-1:0] last_q;
    logic [N_ITER_W-1:0]          iter_q;
    logic [N_ITER_W-1:0]          n_iter_q;
    logic                         fin_q;
    xbar_sel_cfg_t                sel_q;
    logic                         sel_valid_q;
    logic                         busy_q;
    logic                         done_q;

    logic                         tbl_we;
    logic [LOG_N_CFG_ENTRIES-1:0] rd_addr;
    xbar_sel_cfg_t                wr_cfg;
    xbar_sel_cfg_t                rd_cfg;
    xbar_sel_cfg_t                step_cfg;
    logic [LOG_N_CFG_ENTRIES-1:0] cur_ptr;
    logic [LOG_N_CFG_ENTRIES-1:0] cur_last;
    logic [N_ITER_W-1:0]          cur_iter;
    logic [N_ITER_W-1:0]          cur_n_iter;
    logic                         wrap;
    logic [LOG_N_CFG_ENTRIES-1:0] nxt_ptr;
    logic [N_ITER_W-1:0]          nxt_iter;
    logic                         final_step;

    assign tbl_we  = bus.cfg_we_i && (state_q == IDLE);
    assign rd_addr = (state_q == IDLE) ? '0 : ptr_q;
    assign wr_cfg  = '{sel_dmem_pea: bus.cfg_sel_dmem_pea_i, sel_pea_dmem: bus.cfg_sel_pea_dmem_i};

    xbar_sel_cfg_table u_table (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (tbl_we),
        .waddr_i (bus.cfg_addr_i),
        .wdata_i (wr_cfg),
        .raddr_i (rd_addr),
        .rdata_o (rd_cfg)
    );

    // A write landing on the same edge as start must be seen by the first step.
    assign step_cfg = (tbl_we && (bus.cfg_addr_i == rd_addr)) ? wr_cfg : rd_cfg;

    // Step bookkeeping: in IDLE the step being issued is entry 0 of iteration 0 of the new run.
    assign cur_ptr    = (state_q == IDLE) ? '0 : ptr_q;
    assign cur_iter   = (state_q == IDLE) ? '0 : iter_q;
    assign cur_last   = (state_q == IDLE) ? bus.last_entry_i : last_q;
    assign cur_n_iter = (state_q == IDLE) ? bus.n_iter_i : n_iter_q;
    assign wrap       = (cur_ptr == cur_last);
    assign nxt_ptr    = wrap ? '0 : cur_ptr + PTR_ONE;
    assign nxt_iter   = wrap ? cur_iter + ITER_ONE : cur_iter;
    assign final_step = wrap && (cur_iter == cur_n_iter - ITER_ONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            last_q      <= '0;
            iter_q      <= '0;
            n_iter_q    <= '0;
            fin_q       <= 1'b0;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef XBAR_SEL_SCHED_DRAIN_EN
            drain_cnt_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (bus.abort_i) begin
                state_q     <= IDLE;
                ptr_q       <= '0;
                iter_q      <= '0;
                fin_q       <= 1'b0;
                sel_valid_q <= 1'b0;
                busy_q      <= 1'b0;
`ifdef XBAR_SEL_SCHED_DRAIN_EN
                drain_cnt_q <= '0;
`endif
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start_i) begin
                            last_q   <= bus.last_entry_i;
                            n_iter_q <= bus.n_iter_i;
                            if (bus.n_iter_i == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q     <= RUN;
                                busy_q      <= 1'b1;
                                sel_q       <= step_cfg;
                                sel_valid_q <= 1'b1;
                                ptr_q       <= nxt_ptr;
                                iter_q      <= nxt_iter;
                                fin_q       <= final_step;
                            end
                        end
                    end
                    RUN: begin
                        // fin_q: the final step was already shown, so stall no longer applies.
                        if (fin_q) begin
                            fin_q       <= 1'b0;
                            ptr_q       <= '0;
                            iter_q      <= '0;
                            sel_valid_q <= 1'b0;
`ifdef XBAR_SEL_SCHED_DRAIN_EN
                            state_q     <= DRAIN;
                            drain_cnt_q <= DRAIN_LOAD;
`else
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
`endif
                        end else if (bus.stall_i) begin
                            sel_valid_q <= 1'b0;
                        end else begin
                            sel_q       <= step_cfg;
                            sel_valid_q <= 1'b1;
                            ptr_q       <= nxt_ptr;
                            iter_q      <= nxt_iter;
                            fin_q       <= final_step;
                        end
                    end
`ifdef XBAR_SEL_SCHED_DRAIN_EN
                    DRAIN: begin
                        if (drain_cnt_q == '0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            drain_cnt_q <= drain_cnt_q - 1'b1;
                        end
                    end
`endif
                    default: begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        sel_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sel_dmem_pea_o = sel_q.sel_dmem_pea;
    assign bus.sel_pea_dmem_o = sel_q.sel_pea_dmem;
    assign bus.sel_valid_o    = sel_valid_q;
    assign bus.busy_o         = busy_q;
    assign bus.done_o         = done_q;
    assign bus.cfg_ready_o    = (state_q == IDLE);
endmodule

// File: tb/tb_xbar_banks_pea_sel_sched.sv
// Directed vector bench for xbar_banks_pea_sel_sched; follows XBAR_SEL_SCHED_DRAIN_EN when defined.
module tb_xbar_banks_pea_sel_sched;
    logic clk;
    logic rst;

    xbar_banks_pea_sel_sched_if bus ();

    xbar_banks_pea_sel_sched dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Payloads are {sel_dmem_pea[7:0], sel_pea_dmem[7:0]}.
    localparam int E0 = 'h1BE4;
    localparam int E1 = 'h4E39;
    localparam int E2 = 'hC693;
    localparam int EX = 'hFFFF;
    localparam int EN = 'h5AA5;

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [15:0] wcfg;
        logic        start;
        logic [2:0]  last;
        logic [15:0] n;
        logic        stall;
        logic        abort;
        logic        ev;
        logic [15:0] ecfg;
        logic        eb;
        logic        edn;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic vec(input int we, input int addr, input int wcfg, input int start, input int last,
                       input int n, input int stall, input int abort,
                       input int ev, input int ecfg, input int eb, input int edn);
        vec_t v;
        v.we = 1'(we);       v.addr = 3'(addr);   v.wcfg = 16'(wcfg);
        v.start = 1'(start); v.last = 3'(last);   v.n = 16'(n);
        v.stall = 1'(stall); v.abort = 1'(abort);
        v.ev = 1'(ev);       v.ecfg = 16'(ecfg);  v.eb = 1'(eb);    v.edn = 1'(edn);
        vq.push_back(v);
    endtask

    task automatic nop(input int ev, input int ecfg, input int eb, input int edn);
        vec(0, 0, 0, 0, 0, 0, 0, 0, ev, ecfg, eb, edn);
    endtask

    task automatic fin(input int ecfg);
`ifdef XBAR_SEL_SCHED_DRAIN_EN
        for (int k = 0; k < 3; k++) nop(0, ecfg, 1, 0);
`endif
        nop(0, ecfg, 0, 1);
    endtask

    task automatic drive(input vec_t v);
        bus.cfg_we_i           = v.we;
        bus.cfg_addr_i         = v.addr;
        bus.cfg_sel_dmem_pea_i = v.wcfg[15:8];
        bus.cfg_sel_pea_dmem_i = v.wcfg[7:0];
        bus.start_i            = v.start;
        bus.last_entry_i       = v.last;
        bus.n_iter_i           = v.n;
        bus.stall_i            = v.stall;
        bus.abort_i            = v.abort;
    endtask

    task automatic drive_idle();
        vec_t v;
        v = '{default: '0};
        drive(v);
    endtask

    function automatic logic [31:0] sel_now();
        return 32'({bus.sel_dmem_pea_o, bus.sel_pea_dmem_o});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   exp_seq [4];
        int   nvalid;
        logic got_done;
        vec_t v;

        rst = 1'b1;
        drive_idle();

        // Table writes, then plain run last=2 n=2.
        vec(1, 0, E0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vec(1, 1, E1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vec(1, 2, E2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vec(0, 0, 0, 1, 2, 2, 0, 0, 1, E0, 1, 0);
        nop(1, E1, 1, 0); nop(1, E2, 1, 0); nop(1, E0, 1, 0); nop(1, E1, 1, 0); nop(1, E2, 1, 0);
        fin(E2);
        nop(0, E2, 0, 0);
        // Two stall cycles ahead of entry 1.
        vec(0, 0, 0, 1, 2, 2, 0, 0, 1, E0, 1, 0);
        vec(0, 0, 0, 0, 0, 0, 1, 0, 0, E0, 1, 0);
        vec(0, 0, 0, 0, 0, 0, 1, 0, 0, E0, 1, 0);
        nop(1, E1, 1, 0); nop(1, E2, 1, 0); nop(1, E0, 1, 0); nop(1, E1, 1, 0); nop(1, E2, 1, 0);
        fin(E2);
        nop(0, E2, 0, 0);
        // n_iter=0, then start together with abort.
        vec(0, 0, 0, 1, 1, 0, 0, 0, 0, E2, 0, 1);
        nop(0, E2, 0, 0);
        vec(0, 0, 0, 1, 2, 2, 0, 1, 0, E2, 0, 0);
        nop(0, E2, 0, 0);
        // Abort on the third valid step, then restart.
        vec(0, 0, 0, 1, 2, 2, 0, 0, 1, E0, 1, 0);
        nop(1, E1, 1, 0);
        nop(1, E2, 1, 0);
        vec(0, 0, 0, 0, 0, 0, 0, 1, 0, E2, 0, 0);
        nop(0, E2, 0, 0);
        vec(0, 0, 0, 1, 2, 1, 0, 0, 1, E0, 1, 0);
        nop(1, E1, 1, 0); nop(1, E2, 1, 0);
        fin(E2);
        nop(0, E2, 0, 0);
        // Write and start while running are ignored.
        vec(0, 0, 0, 1, 0, 2, 0, 0, 1, E0, 1, 0);
        vec(1, 0, EX, 1, 2, 5, 0, 0, 1, E0, 1, 0);
        fin(E0);
        vec(0, 0, 0, 1, 0, 1, 0, 0, 1, E0, 1, 0);
        fin(E0);
        // Write in the same cycle as start is used by the run.
        vec(1, 1, EN, 1, 1, 1, 0, 0, 1, E0, 1, 0);
        nop(1, EN, 1, 0);
        fin(EN);
        nop(0, EN, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset valid", 32'(bus.sel_valid_o), 32'(0));
        check("reset busy", 32'(bus.busy_o), 32'(0));
        check("reset done", 32'(bus.done_o), 32'(0));
        check("reset ready", 32'(bus.cfg_ready_o), 32'(1));
        check("reset sel", sel_now(), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            @(negedge clk);
            drive(v);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d valid", i), 32'(bus.sel_valid_o), 32'(v.ev));
            check($sformatf("vec%0d sel_dmem_pea", i), 32'(bus.sel_dmem_pea_o), 32'(v.ecfg[15:8]));
            check($sformatf("vec%0d sel_pea_dmem", i), 32'(bus.sel_pea_dmem_o), 32'(v.ecfg[7:0]));
            check($sformatf("vec%0d busy", i), 32'(bus.busy_o), 32'(v.eb));
            check($sformatf("vec%0d done", i), 32'(bus.done_o), 32'(v.edn));
            check($sformatf("vec%0d ready", i), 32'(bus.cfg_ready_o), 32'(!v.eb));
        end
        @(negedge clk);
        drive_idle();

        // Longer run with periodic stalls: entries 0..3, three iterations.
        exp_seq = '{E0, EN, E2, 0};
        nvalid = 0;
        got_done = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b1; bus.last_entry_i = 3'd3; bus.n_iter_i = 16'd3;
        for (int c = 0; c < 100 && !got_done; c++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            if (bus.sel_valid_o) begin
                check($sformatf("stallrun step%0d sel", nvalid), sel_now(), 32'(exp_seq[nvalid % 4]));
                nvalid++;
            end
            if (bus.done_o) begin
                got_done = 1'b1;
                check("stallrun busy at done", 32'(bus.busy_o), 32'(0));
            end
            bus.stall_i = (c % 3 == 1);
        end
        bus.stall_i = 1'b0;
        check("stallrun done seen", 32'(got_done), 32'(1));
        check("stallrun valid steps", 32'(nvalid), 32'(12));
        @(negedge clk);
        check("stallrun single done", 32'(bus.done_o), 32'(0));

`ifdef XBAR_SEL_SCHED_DRAIN_EN
        // Drain ignores stall; abort cancels it.
        bus.start_i = 1'b1; bus.last_entry_i = 3'd0; bus.n_iter_i = 16'd1;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.stall_i = 1'b1;
        check("drain step valid", 32'(bus.sel_valid_o), 32'(1));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("drain%0d busy", k), 32'(bus.busy_o), 32'(1));
            check($sformatf("drain%0d valid", k), 32'(bus.sel_valid_o), 32'(0));
            check($sformatf("drain%0d done", k), 32'(bus.done_o), 32'(0));
        end
        @(negedge clk);
        bus.stall_i = 1'b0;
        check("drain done", 32'(bus.done_o), 32'(1));
        check("drain busy end", 32'(bus.busy_o), 32'(0));
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        @(negedge clk);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        check("drain abort busy", 32'(bus.busy_o), 32'(0));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("drain abort no done%0d", k), 32'(bus.done_o), 32'(0));
        end
`endif

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        bus.start_i = 1'b1; bus.last_entry_i = 3'd2; bus.n_iter_i = 16'd2;
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async rst valid", 32'(bus.sel_valid_o), 32'(0));
        check("async rst busy", 32'(bus.busy_o), 32'(0));
        check("async rst sel", sel_now(), 32'(0));
        check("async rst ready", 32'(bus.cfg_ready_o), 32'(1));
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("after rst no done%0d", k), 32'(bus.done_o), 32'(0));
        end
        bus.start_i = 1'b1; bus.last_entry_i = 3'd0; bus.n_iter_i = 16'd1;
        @(negedge clk);
        bus.start_i = 1'b0;
        check("after rst valid", 32'(bus.sel_valid_o), 32'(1));
        check("after rst table cleared", sel_now(), 32'(0));
`ifdef XBAR_SEL_SCHED_DRAIN_EN
        repeat (3) @(negedge clk);
`endif
        @(negedge clk);
        check("after rst done", 32'(bus.done_o), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
